// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR stream core and the Wishbone front end.
package fir_pkg;

    localparam int FIR_TAP_NUM = 11;
    localparam int WORD_SHIFT  = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        MAC,
        OUT,
        DONE
    } fir_state_e;

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate datapath: signed product truncated to DATA_W, wrapping accumulation.
module fir_mac #(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] coef,
    input  logic signed [DATA_W-1:0] sample,
    output logic        [DATA_W-1:0] acc
);

    // A DATA_W-wide context keeps only the low bits of the full product.
    logic signed [DATA_W-1:0] product;
    assign product = coef * sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + product;
        end
    end

endmodule

// File: rtl/fir_stream_core.sv
// Streaming FIR core: circular sample buffer in data BRAM, taps in tap BRAM, one MAC per cycle.
module fir_stream_core
    import fir_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TAP_NUM = FIR_TAP_NUM,
    parameter int ADDR_W  = 12
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              ap_start,
    input  logic [31:0]       data_length,
    output logic              ap_done,
    output logic              ap_idle,
    input  logic              ss_tvalid,
    input  logic [DATA_W-1:0] ss_tdata,
    input  logic              ss_tlast,
    output logic              ss_tready,
    output logic              sm_tvalid,
    output logic [DATA_W-1:0] sm_tdata,
    output logic              sm_tlast,
    input  logic              sm_tready,
    output logic              tap_EN,
    output logic [ADDR_W-1:0] tap_A,
    input  logic [DATA_W-1:0] tap_Do,
    output logic              data_EN,
    output logic [3:0]        data_WE,
    output logic [ADDR_W-1:0] data_A,
    output logic [DATA_W-1:0] data_Di,
    input  logic [DATA_W-1:0] data_Do
);

    localparam int                CNT_W    = $clog2(TAP_NUM + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TAP_NUM - 1);
    localparam logic [CNT_W-1:0] TAP_IDX  = CNT_W'(TAP_NUM);

    fir_state_e        state, state_next;
    logic [CNT_W-1:0]  idx, wptr, rd_idx;
    logic [31:0]       len_q, count;
    logic [DATA_W-1:0] acc;
    logic              mac_clear, mac_en, last_sample;

    // The input stream's last flag carries no information the sample count lacks.
    logic unused_tlast;
    assign unused_tlast = ss_tlast;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [CNT_W-1:0] word);
        return ADDR_W'(word) << WORD_SHIFT;
    endfunction

    assign last_sample = (count + 32'd1) == len_q;
    assign sm_tdata    = acc;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // idx walks the CLEAR words and the MAC cycles; rd_idx walks the history backwards.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            idx    <= '0;
            wptr   <= '0;
            rd_idx <= '0;
            count  <= '0;
            len_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ap_start) begin
                        len_q <= data_length;
                        count <= '0;
                        wptr  <= '0;
                        idx   <= '0;
                    end
                end
                CLEAR: idx <= idx + 1'b1;
                LOAD: begin
                    if (ss_tvalid) begin
                        idx    <= '0;
                        rd_idx <= wptr;
                    end
                end
                MAC: begin
                    idx <= idx + 1'b1;
                    if (idx != TAP_IDX) begin
                        rd_idx <= (rd_idx == '0) ? LAST_IDX : rd_idx - 1'b1;
                    end
                end
                OUT: begin
                    if (sm_tready) begin
                        count <= count + 32'd1;
                        wptr  <= (wptr == LAST_IDX) ? '0 : wptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        ap_idle    = 1'b0;
        ap_done    = 1'b0;
        ss_tready  = 1'b0;
        sm_tvalid  = 1'b0;
        sm_tlast   = 1'b0;
        tap_EN     = 1'b0;
        tap_A      = '0;
        data_EN    = 1'b0;
        data_WE    = 4'h0;
        data_A     = '0;
        data_Di    = '0;
        mac_clear  = 1'b0;
        mac_en     = 1'b0;
        unique case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_next = CLEAR;
            end
            CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = word_addr(idx);
                if (idx == LAST_IDX) state_next = (len_q == '0) ? DONE : LOAD;
            end
            LOAD: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    data_EN    = 1'b1;
                    data_WE    = 4'hF;
                    data_A     = word_addr(wptr);
                    data_Di    = ss_tdata;
                    state_next = MAC;
                end
            end
            MAC: begin
                // Reads issue on cycles 0..TAP_NUM-1 and land one cycle later in the MAC.
                if (idx != TAP_IDX) begin
                    tap_EN  = 1'b1;
                    tap_A   = word_addr(idx);
                    data_EN = 1'b1;
                    data_A  = word_addr(rd_idx);
                end else begin
                    state_next = OUT;
                end
                mac_clear = (idx == '0);
                mac_en    = (idx != '0);
            end
            OUT: begin
                sm_tvalid = 1'b1;
                sm_tlast  = last_sample;
                if (sm_tready) state_next = last_sample ? DONE : LOAD;
            end
            DONE: begin
                ap_done    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    fir_mac #(
        .DATA_W(DATA_W)
    ) u_mac (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .clear (mac_clear),
        .enable(mac_en),
        .coef  (tap_Do),
        .sample(data_Do),
        .acc   (acc)
    );

endmodule

// File: tb/tb_fir_stream_core.sv
// Directed self-checking bench for fir_stream_core with behavioural tap and data BRAMs.
module tb_fir_stream_core;

    localparam int DATA_W  = 32;
    localparam int TAP_NUM = 11;
    localparam int ADDR_W  = 12;

    logic              wb_clk_i;
    logic              wb_rst_i;
    logic              ap_start;
    logic [31:0]       data_length;
    logic              ap_done;
    logic              ap_idle;
    logic              ss_tvalid;
    logic [DATA_W-1:0] ss_tdata;
    logic              ss_tlast;
    logic              ss_tready;
    logic              sm_tvalid;
    logic [DATA_W-1:0] sm_tdata;
    logic              sm_tlast;
    logic              sm_tready;
    logic              tap_EN;
    logic [ADDR_W-1:0] tap_A;
    logic [DATA_W-1:0] tap_Do;
    logic              data_EN;
    logic [3:0]        data_WE;
    logic [ADDR_W-1:0] data_A;
    logic [DATA_W-1:0] data_Di;
    logic [DATA_W-1:0] data_Do;

    logic [31:0] tap_mem  [0:4095];
    logic [31:0] data_mem [0:4095];
    logic [31:0] coef     [0:10];
    logic [31:0] stim     [0:31];
    logic [31:0] expv     [0:31];
    int          ramp_taps [0:10] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    int errors;
    int checks;
    int done_cnt;
    int valid_cnt;

    fir_stream_core #(
        .DATA_W (DATA_W),
        .TAP_NUM(TAP_NUM),
        .ADDR_W (ADDR_W)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .ap_start   (ap_start),
        .data_length(data_length),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ss_tvalid  (ss_tvalid),
        .ss_tdata   (ss_tdata),
        .ss_tlast   (ss_tlast),
        .ss_tready  (ss_tready),
        .sm_tvalid  (sm_tvalid),
        .sm_tdata   (sm_tdata),
        .sm_tlast   (sm_tlast),
        .sm_tready  (sm_tready),
        .tap_EN     (tap_EN),
        .tap_A      (tap_A),
        .tap_Do     (tap_Do),
        .data_EN    (data_EN),
        .data_WE    (data_WE),
        .data_A     (data_A),
        .data_Di    (data_Di),
        .data_Do    (data_Do)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    // Both RAMs have one cycle of read latency; reads return pre-write contents.
    always @(posedge wb_clk_i) begin
        if (tap_EN) tap_Do <= tap_mem[tap_A >> 2];
        if (data_EN) begin
            if (data_WE == 4'hF) data_mem[data_A >> 2] <= data_Di;
            data_Do <= data_mem[data_A >> 2];
        end
    end

    always @(negedge wb_clk_i) begin
        if (ap_done) done_cnt++;
        if (sm_tvalid) valid_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic loadTaps();
        for (int k = 0; k < TAP_NUM; k++) tap_mem[k] = coef[k];
    endtask

    // Direct-form reference over the full input history, independent of any circular buffer.
    function automatic logic [31:0] refOutput(input int n);
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < TAP_NUM; k++) begin
            if (n - k >= 0) s = s + coef[k] * stim[n - k];
        end
        return s;
    endfunction

    task automatic startRun(input logic [31:0] len);
        data_length = len;
        ap_start    = 1'b1;
        @(posedge wb_clk_i); #1;
        ap_start = 1'b0;
    endtask

    task automatic pushSample(input logic [31:0] value);
        int n;
        n         = 0;
        ss_tvalid = 1'b1;
        ss_tdata  = value;
        while (!ss_tready && n < 200) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
        checkOutput("ss_handshake", 32'(ss_tready), 32'd1);
        @(posedge wb_clk_i); #1;
        ss_tvalid = 1'b0;
    endtask

    task automatic waitOutput(output int lat);
        lat = 1;
        while (!sm_tvalid && lat < 200) begin
            @(posedge wb_clk_i); #1;
            lat++;
        end
        checkOutput("sm_tvalid_seen", 32'(sm_tvalid), 32'd1);
    endtask

    task automatic popSample(input logic [31:0] exp, input logic exp_last, input int hold);
        logic [31:0] held;
        held      = sm_tdata;
        sm_tready = 1'b0;
        for (int c = 0; c < hold; c++) begin
            @(posedge wb_clk_i); #1;
            checkOutput("bp_data", sm_tdata, held);
            checkOutput("bp_valid", 32'(sm_tvalid), 32'd1);
            checkOutput("bp_ss_tready", 32'(ss_tready), 32'd0);
        end
        checkOutput("sm_tdata", sm_tdata, exp);
        checkOutput("sm_tlast", 32'(sm_tlast), 32'(exp_last));
        sm_tready = 1'b1;
        @(posedge wb_clk_i); #1;
        sm_tready = 1'b0;
    endtask

    task automatic applyStimulus(input int len, input int hold);
        int lat;
        int d0;
        d0 = done_cnt;
        startRun(len);
        for (int i = 0; i < len; i++) begin
            pushSample(stim[i]);
            waitOutput(lat);
            if (i == 0) checkOutput("latency", lat, TAP_NUM + 2);
            popSample(expv[i], i == len - 1, hold);
        end
        repeat (2) begin
            @(posedge wb_clk_i); #1;
        end
        checkOutput("done_pulses", done_cnt - d0, 32'd1);
        checkOutput("idle_after", 32'(ap_idle), 32'd1);
    endtask

    initial begin
        int lat;
        int n;
        int d0;
        int v0;
        errors      = 0;
        checks      = 0;
        done_cnt    = 0;
        valid_cnt   = 0;
        wb_rst_i    = 1'b1;
        ap_start    = 1'b0;
        data_length = 32'd0;
        ss_tvalid   = 1'b0;
        ss_tdata    = 32'd0;
        ss_tlast    = 1'b0;
        sm_tready   = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        checkOutput("rst_ap_idle", 32'(ap_idle), 32'd1);
        checkOutput("rst_ap_done", 32'(ap_done), 32'd0);
        checkOutput("rst_ss_tready", 32'(ss_tready), 32'd0);
        checkOutput("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
        checkOutput("rst_sm_tdata", sm_tdata, 32'd0);
        checkOutput("rst_tap_EN", 32'(tap_EN), 32'd0);
        checkOutput("rst_data_EN", 32'(data_EN), 32'd0);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;

        // Impulse through taps 1..11 reproduces the taps.
        for (int k = 0; k < TAP_NUM; k++) coef[k] = 32'(k + 1);
        loadTaps();
        for (int i = 0; i < 11; i++) begin
            stim[i] = (i == 0) ? 32'd1 : 32'd0;
            expv[i] = 32'(i + 1);
        end
        applyStimulus(11, 0);

        // Symmetric taps over a 1..25 ramp; the write pointer wraps twice.
        for (int k = 0; k < TAP_NUM; k++) coef[k] = 32'(ramp_taps[k]);
        loadTaps();
        for (int i = 0; i < 25; i++) stim[i] = 32'(i + 1);
        for (int i = 0; i < 25; i++) expv[i] = refOutput(i);
        checkOutput("ref_y0", expv[0], 32'd0);
        checkOutput("ref_y2", expv[2], 32'(-29));
        applyStimulus(25, 0);

        stim[0] = 32'd100;
        stim[1] = 32'(-3);
        stim[2] = 32'd77;
        stim[3] = 32'd12;
        for (int i = 0; i < 4; i++) expv[i] = refOutput(i);
        applyStimulus(4, 5);

        // Zero-length run: CLEAR only, then a single done pulse.
        d0          = done_cnt;
        v0          = valid_cnt;
        n           = 0;
        data_length = 32'd0;
        ap_start    = 1'b1;
        while (!ap_done && n < 50) begin
            @(posedge wb_clk_i); #1;
            ap_start = 1'b0;
            n++;
        end
        checkOutput("zl_done_cycle", n, TAP_NUM + 1);
        repeat (3) begin
            @(posedge wb_clk_i); #1;
        end
        checkOutput("zl_done_pulses", done_cnt - d0, 32'd1);
        checkOutput("zl_no_valid", valid_cnt - v0, 32'd0);

        // 0x7FFFFFFF squared is 0x3FFFFFFF_00000001, so sample n sums to n+1 in the low word.
        for (int k = 0; k < TAP_NUM; k++) coef[k] = 32'h7FFF_FFFF;
        loadTaps();
        for (int i = 0; i < 11; i++) begin
            stim[i] = 32'h7FFF_FFFF;
            expv[i] = 32'(i + 1);
        end
        applyStimulus(11, 0);

        // Abort during the MAC of sample 3, then check a fresh run sees no stale history.
        for (int k = 0; k < TAP_NUM; k++) coef[k] = 32'(k + 1);
        loadTaps();
        stim[0] = 32'd5;
        stim[1] = 32'd6;
        stim[2] = 32'd7;
        expv[0] = 32'd5;
        expv[1] = 32'd16;
        startRun(32'd11);
        for (int i = 0; i < 2; i++) begin
            pushSample(stim[i]);
            waitOutput(lat);
            popSample(expv[i], 1'b0, 0);
        end
        pushSample(stim[2]);
        repeat (3) begin
            @(posedge wb_clk_i); #1;
        end
        d0 = done_cnt;
        v0 = valid_cnt;
        #2;
        wb_rst_i = 1'b1;
        #1;
        checkOutput("mid_rst_idle", 32'(ap_idle), 32'd1);
        checkOutput("mid_rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
        checkOutput("mid_rst_sm_tdata", sm_tdata, 32'd0);
        checkOutput("mid_rst_data_EN", 32'(data_EN), 32'd0);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        repeat (6) begin
            @(posedge wb_clk_i); #1;
        end
        checkOutput("mid_rst_no_done", done_cnt - d0, 32'd0);
        checkOutput("mid_rst_no_valid", valid_cnt - v0, 32'd0);
        for (int i = 0; i < 11; i++) begin
            stim[i] = (i == 0) ? 32'd1 : 32'd0;
            expv[i] = 32'(i + 1);
        end
        applyStimulus(11, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
